// File: rtl/opamp_seq_pkg.sv
// Shared state encoding and default timing for the opamp mux sequencer.
package opamp_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CONNECT = 2'd2;
  localparam state_t ST_BBM     = 2'd3;

  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int DWELL_CYCLES_DEF  = 64;
  localparam int BBM_CYCLES_DEF    = 2;

endpackage

// File: rtl/opamp_seq_next_ch.sv
// Finds the next set mask bit above idx, wrapping to the lowest set bit.
// With from_zero=1 it simply returns the lowest set bit.
module opamp_seq_next_ch #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             from_zero,
  output logic [SEL_W-1:0] next_ch,
  output logic             wrap,
  output logic             found
);

  logic [SEL_W-1:0] above_ch;
  logic [SEL_W-1:0] low_ch;
  logic             above_found;
  logic             low_found;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    above_ch    = '0;
    low_ch      = '0;
    above_found = 1'b0;
    low_found   = 1'b0;
    // Descending scan: the last hit written is the lowest qualifying bit.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ch    = SEL_W'(i);
        low_found = 1'b1;
        if (from_zero || (i > int'(idx))) begin
          above_ch    = SEL_W'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign found   = low_found;
  assign wrap    = ~above_found;
  assign next_ch = above_found ? above_ch : low_ch;

endmodule

// File: rtl/opamp_mux_sequencer.sv
// Sequences opamp enable / output switch per channel with settle, dwell and
// break-before-make phases; auto sweep over a mask or manual req/ack service.
module opamp_mux_sequencer
  import opamp_seq_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SEL_W         = 3,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DWELL_CYCLES  = DWELL_CYCLES_DEF,
  parameter int BBM_CYCLES    = BBM_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             man_req,
  input  logic [SEL_W-1:0] man_sel,
  output logic             man_ack,
  output logic             man_err,
  output logic [N_CH-1:0]  opamp_en,
  output logic [N_CH-1:0]  sw_en,
  output logic [SEL_W-1:0] cur_ch,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ch;
  logic [N_CH-1:0]  mask_q;
  logic             manual;
  logic             aborted;
  logic             done_q;
  logic             man_err_q;
  logic             man_req_q;

  logic [N_CH-1:0]  search_mask;
  logic             search_first;
  logic [SEL_W-1:0] search_ch;
  logic             search_wrap;
  logic             search_found;
  logic             man_sel_ok;
  logic [N_CH-1:0]  ch_onehot;

  // One search unit: lowest set bit of ch_mask in IDLE, successor of ch otherwise.
  assign search_first = (state == ST_IDLE);
  assign search_mask  = search_first ? ch_mask : mask_q;
  assign man_sel_ok   = ({1'b0, man_sel} < (SEL_W + 1)'(N_CH));

  opamp_seq_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask      (search_mask),
    .idx       (ch),
    .from_zero (search_first),
    .next_ch   (search_ch),
    .wrap      (search_wrap),
    .found     (search_found)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ch        <= '0;
      mask_q    <= '0;
      manual    <= 1'b0;
      aborted   <= 1'b0;
      done_q    <= 1'b0;
      man_err_q <= 1'b0;
      man_req_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      man_err_q <= 1'b0;
      man_req_q <= man_req;
      case (state)
        ST_IDLE: begin
          if (!stop) begin
            if (man_req && man_sel_ok) begin
              state   <= ST_SETTLE;
              ch      <= man_sel;
              manual  <= 1'b1;
              aborted <= 1'b0;
              cnt     <= SETTLE_LOAD;
            end else if (man_req) begin
              man_err_q <= ~man_req_q;
            end else if (start && search_found) begin
              state   <= ST_SETTLE;
              ch      <= search_ch;
              mask_q  <= ch_mask;
              manual  <= 1'b0;
              aborted <= 1'b0;
              cnt     <= SETTLE_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          if (stop) begin
            state   <= ST_BBM;
            aborted <= 1'b1;
            cnt     <= BBM_LOAD;
          end else if (cnt == '0) begin
            state <= ST_CONNECT;
            cnt   <= DWELL_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CONNECT: begin
          if (stop) begin
            state   <= ST_BBM;
            aborted <= 1'b1;
            cnt     <= BBM_LOAD;
          end else if (manual ? !man_req : (cnt == '0)) begin
            state <= ST_BBM;
            cnt   <= BBM_LOAD;
          end else if (!manual) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BBM: begin
          if (stop) aborted <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (manual || aborted || stop || (search_wrap && !loop)) begin
            // A completed single sweep is the only exit that reports done.
            done_q <= !manual && !aborted && !stop;
            state  <= ST_IDLE;
            ch     <= '0;
          end else begin
            state <= ST_SETTLE;
            ch    <= search_ch;
            cnt   <= SETTLE_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ch_onehot = N_CH'(1) << ch;
  assign opamp_en  = ((state == ST_SETTLE) || (state == ST_CONNECT)) ? ch_onehot : '0;
  assign sw_en     = (state == ST_CONNECT) ? ch_onehot : '0;
  assign man_ack   = manual && (state == ST_CONNECT);
  assign cur_ch    = ch;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign man_err   = man_err_q;

  a_sw_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sw_en));
  a_en_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(opamp_en));
  a_sw_subset: assert property (@(posedge clk) disable iff (rst) ((sw_en & ~opamp_en) == '0));

endmodule

// File: tb/tb_opamp_mux_sequencer.sv
// Self-checking bench: directed and randomized sweeps/manual requests against
// a timeline model derived from the channel period arithmetic.
module tb_opamp_mux_sequencer;

  localparam int S = 16;
  localparam int D = 64;
  localparam int B = 2;
  localparam int P = S + D + B;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] ch_mask;
  logic       man_req;
  logic [2:0] man_sel;
  logic       man_ack;
  logic       man_err;
  logic [3:0] opamp_en;
  logic [3:0] sw_en;
  logic [2:0] cur_ch;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  opamp_mux_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .ch_mask  (ch_mask),
    .man_req  (man_req),
    .man_sel  (man_sel),
    .man_ack  (man_ack),
    .man_err  (man_err),
    .opamp_en (opamp_en),
    .sw_en    (sw_en),
    .cur_ch   (cur_ch),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pk(bit err, bit ack, bit dn, bit bz, int cc,
                                     logic [3:0] se, logic [3:0] oe);
    return {err, ack, dn, bz, 3'(cc), se, oe};
  endfunction

  function automatic logic [14:0] observed();
    return {man_err, man_ack, done, busy, cur_ch, sw_en, opamp_en};
  endfunction

  // Auto sweep timeline: channel k of the set-bit list owns cycles
  // 1+k*P .. (k+1)*P; stop at cycle stop_at gives two BBM cycles then idle.
  function automatic logic [14:0] sweep_exp(int t, logic [3:0] mask, bit lp, int stop_at);
    int         list[4];
    int         n = 0;
    int         tt, idx, ph;
    int         cc = 0;
    logic [3:0] oe = '0;
    logic [3:0] se = '0;
    bit         bz = 0;
    bit         dn = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) begin list[n] = i; n++; end
    tt  = (stop_at > 0 && t > stop_at) ? stop_at : t;
    idx = (tt - 1) / P;
    ph  = (tt - 1) % P;
    if (lp) idx = idx % n;
    if (tt >= 1 && idx < n) begin
      bz = 1;
      cc = list[idx];
      if (ph < S + D) oe[cc] = 1'b1;
      if (ph >= S && ph < S + D) se[cc] = 1'b1;
    end else if (!lp && t == n * P + 1) begin
      dn = 1;
    end
    if (stop_at > 0 && t > stop_at) begin
      oe = '0;
      se = '0;
      dn = 0;
      bz = (t <= stop_at + 2);
      if (!bz) cc = 0;
    end
    return pk(0, 0, dn, bz, cc, se, oe);
  endfunction

  // Manual timeline: req high in cycles 0..L-1; connect from S+1 until the
  // first cycle req is seen low in CONNECT, then two BBM cycles.
  function automatic int manual_end(int L);
    return (L >= S + 1) ? L : S + 1;
  endfunction

  function automatic logic [14:0] manual_exp(int t, int sel, int L);
    int         e = manual_end(L);
    logic [3:0] oe = '0;
    logic [3:0] se = '0;
    bit         ack = 0;
    if (t >= 1 && t <= e + 2) begin
      if (t <= e) oe[sel] = 1'b1;
      if (t >= S + 1 && t <= e) begin
        se[sel] = 1'b1;
        ack = 1;
      end
      return pk(0, ack, 0, 1, sel, se, oe);
    end
    return '0;
  endfunction

  task automatic run_sweep(input string tag, input logic [3:0] mask, input bit lp,
                           input int stop_at, input int ncyc, input bit scramble);
    ch_mask = mask;
    loop    = lp;
    start   = 1'b1;
    stop    = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      step();
      check(tag, observed(), sweep_exp(t, mask, lp, stop_at));
      start = 1'b0;
      stop  = (t == stop_at);
      if (scramble) ch_mask = 4'($urandom);
    end
    stop = 1'b0;
    loop = 1'b0;
  endtask

  task automatic run_manual(input string tag, input int sel, input int L, input bit with_start);
    int e = manual_end(L);
    man_sel = 3'(sel);
    man_req = 1'b1;
    if (with_start) begin
      ch_mask = 4'hF;
      start   = 1'b1;
    end
    for (int t = 1; t <= e + 4; t++) begin
      step();
      check(tag, observed(), manual_exp(t, sel, L));
      start = 1'b0;
      if (t >= L) man_req = 1'b0;
    end
  endtask

  task automatic run_bad_sel(input int sel);
    man_sel = 3'(sel);
    man_req = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      step();
      check("bad_sel", observed(), (t == 1) ? pk(1, 0, 0, 0, 0, '0, '0) : '0);
      if (t == 4) man_req = 1'b0;
    end
  endtask

  task automatic run_reset_at(input string tag, input int k);
    ch_mask = 4'b0010;
    loop    = 1'b0;
    start   = 1'b1;
    for (int t = 1; t <= k; t++) begin
      step();
      check(tag, observed(), sweep_exp(t, 4'b0010, 0, 0));
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    check({tag, "_zero"}, observed(), '0);
    rst = 1'b0;
    run_sweep({tag, "_restart"}, 4'b0010, 0, 0, P + 3, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] m;
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;
    ch_mask = '0;
    man_req = 1'b0;
    man_sel = '0;
    step();
    step();
    check("reset", observed(), '0);
    rst = 1'b0;
    step();
    check("idle", observed(), '0);

    run_sweep("sweep_0101", 4'b0101, 0, 0, 2 * P + 4, 0);

    // Loop on one channel with a scrambled mask, then stop in CONNECT.
    run_sweep("loop_1000", 4'b1000, 1, 2 * P + 25, 2 * P + 30, 1);

    run_manual("manual_sel1", 1, 100, 0);
    run_bad_sel(5);
    run_bad_sel(4 + int'($urandom_range(3)));
    run_manual("man_vs_start", 2, 30, 1);

    ch_mask = '0;
    start   = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      check("start_mask0", observed(), '0);
    end
    start = 1'b0;

    run_reset_at("rst_settle", 5);
    run_reset_at("rst_connect", 40);

    for (int r = 0; r < 3; r++) begin
      m = 4'($urandom_range(15, 1));
      run_sweep("rand_sweep", m, 0, 0, $countones(m) * P + 3, 0);
    end
    for (int r = 0; r < 3; r++) begin
      run_manual("rand_manual", int'($urandom_range(3)), int'($urandom_range(60, 1)), 0);
    end

    // Random control traffic; only the structural invariants are predictable here.
    for (int t = 0; t < 2000; t++) begin
      stop    = ($urandom_range(15) == 0);
      start   = ($urandom_range(3) == 0);
      ch_mask = 4'($urandom);
      loop    = 1'($urandom);
      if ($urandom_range(19) == 0) begin
        if (!man_req) man_sel = 3'($urandom);
        man_req = ~man_req;
      end
      step();
      check("inv_sw_onehot", 15'($onehot0(sw_en)), 15'd1);
      check("inv_en_onehot", 15'($onehot0(opamp_en)), 15'd1);
      check("inv_subset", 15'((sw_en & ~opamp_en) == 4'b0), 15'd1);
      check("inv_idle_quiet", 15'(busy || (opamp_en == 4'b0 && cur_ch == 3'b0)), 15'd1);
    end
    man_req = 1'b0;
    start   = 1'b0;
    stop    = 1'b1;
    for (int t = 0; t < 4; t++) step();
    stop = 1'b0;
    step();
    check("stop_to_idle", observed(), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
